// File: rtl/vec_seq_pkg.sv
// Shared constants for the vector sequencer: FSM state codes, word indices
// within a vector and the default minimum test-cycle length.
package vec_seq_pkg;

  localparam int DEFAULT_MIN_LEN = 8;

  localparam int WORD_SIG  = 0;
  localparam int WORD_FF   = 1;
  localparam int WORD_TMPL = 2;
  localparam int WORD_CYC  = 3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_PRIME  = 3'd1;
  localparam state_t ST_RUN    = 3'd2;
  localparam state_t ST_DRAIN  = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

  function automatic logic [3:0] word_strobe(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/vector_period_ctr.sv
// 8-bit test-cycle counter that runs 0..len-1 and wraps; boundary marks the
// last clock of the period.
module vector_period_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] len,
  output logic       boundary
);

  logic [7:0] count;

  assign boundary = (count == len - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= 8'd0;
    else if (clear)
      count <= 8'd0;
    else if (enable)
      count <= boundary ? 8'd0 : count + 8'd1;
  end

endmodule

// File: rtl/vector_sequencer.sv
// Fetches four-word test vectors from vector RAM, presents each word on the
// shared bus with its LOAD strobe and transfers whole vectors on period boundaries.
module vector_sequencer
  import vec_seq_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int CNT_W   = 10,
  parameter int MIN_LEN = DEFAULT_MIN_LEN
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [CNT_W-1:0]  NUM_VECTORS,
  input  logic [7:0]        CYCLE_LENGTH_1,
  output logic              MEM_RD,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_GNT,
  input  logic [127:0]      MEM_DATA,
  output logic [127:0]      BUS128,
  output logic              SIG_LOAD,
  output logic              FF_LOAD,
  output logic              TEMPLATE_LOAD,
  output logic              CYCLE_LOAD,
  output logic              SIG_TRANSFER,
  output logic              FF_TRANSFER,
  output logic              TEMPLATE_TRANSFER,
  output logic              CYCLE_TRANSFER,
  output logic              PERFORM_TEST,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR_CFG,
  output logic              ERR_UNDERRUN
);

  localparam logic [7:0] MIN_LEN_8 = 8'(MIN_LEN);

  state_t              state, state_d;
  logic [7:0]          len_q;
  logic [CNT_W-1:0]    vec_left;
  logic                fetch_active;
  logic [1:0]          req_idx;
  logic [ADDR_W-1:0]   fetch_addr;
  logic                rd_pend;
  logic [1:0]          rd_word;
  logic [3:0]          load_q;
  logic [127:0]        bus_q;
  logic [2:0]          loaded_cnt;
  logic                perf_q;
  logic                err_cfg_q;
  logic                err_und_q;

  logic busy, boundary, loads_full, more, cfg_bad, no_vectors;
  logic start_ok, start_run, grant, xfer, underrun, stop;

  assign busy       = (state == ST_PRIME) || (state == ST_RUN) || (state == ST_DRAIN);
  assign loads_full = (loaded_cnt == 3'd4);
  assign more       = (vec_left != '0);
  assign cfg_bad    = (CYCLE_LENGTH_1 < MIN_LEN_8);
  assign no_vectors = (NUM_VECTORS == '0);
  assign start_ok   = START && (state == ST_IDLE);
  assign start_run  = start_ok && !cfg_bad && !no_vectors;
  assign grant      = fetch_active && MEM_GNT;

  // ABORT wins over a boundary transfer and never counts as an underrun
  assign xfer     = !ABORT && loads_full && ((state == ST_PRIME) || ((state == ST_RUN) && boundary));
  assign underrun = !ABORT && (state == ST_RUN) && boundary && !loads_full;
  assign stop     = (ABORT && busy) || underrun || ((state == ST_DRAIN) && boundary);

  vector_period_ctr u_period (
    .clk      (CLK),
    .rst      (RST),
    .clear    (xfer),
    .enable   ((state == ST_RUN) || (state == ST_DRAIN)),
    .len      (len_q),
    .boundary (boundary)
  );

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:
        if (START) state_d = (cfg_bad || no_vectors) ? ST_FINISH : ST_PRIME;
      ST_PRIME, ST_RUN:
        if (stop)      state_d = ST_FINISH;
        else if (xfer) state_d = more ? ST_RUN : ST_DRAIN;
      ST_DRAIN:
        if (stop) state_d = ST_FINISH;
      ST_FINISH:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      len_q     <= 8'd0;
      perf_q    <= 1'b0;
      err_cfg_q <= 1'b0;
      err_und_q <= 1'b0;
    end else begin
      state <= state_d;
      if (start_ok) begin
        len_q     <= CYCLE_LENGTH_1;
        err_cfg_q <= cfg_bad;
        err_und_q <= 1'b0;
      end else if (underrun) begin
        err_und_q <= 1'b1;
      end
      if (stop)
        perf_q <= 1'b0;
      else if (xfer)
        perf_q <= 1'b1;
    end
  end

  // The fetch address keeps advancing across vectors, so vector n+1 starts
  // exactly where vector n's fourth word left off.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_active <= 1'b0;
      req_idx      <= 2'd0;
      fetch_addr   <= '0;
      vec_left     <= '0;
    end else if (start_run) begin
      fetch_active <= 1'b1;
      req_idx      <= 2'd0;
      fetch_addr   <= BASE_ADDR;
      vec_left     <= NUM_VECTORS - CNT_W'(1);
    end else if (stop) begin
      fetch_active <= 1'b0;
    end else if (xfer && more) begin
      fetch_active <= 1'b1;
      req_idx      <= 2'd0;
      vec_left     <= vec_left - CNT_W'(1);
    end else if (grant) begin
      fetch_addr <= fetch_addr + ADDR_W'(1);
      req_idx    <= req_idx + 2'd1;
      if (req_idx == 2'd3) fetch_active <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_pend    <= 1'b0;
      rd_word    <= 2'd0;
      load_q     <= 4'd0;
      bus_q      <= '0;
      loaded_cnt <= 3'd0;
    end else begin
      rd_pend <= grant && !stop;
      rd_word <= req_idx;
      if (rd_pend && !stop) begin
        load_q <= word_strobe(rd_word);
        bus_q  <= MEM_DATA;
      end else begin
        load_q <= 4'd0;
      end
      if (start_ok || xfer || stop)
        loaded_cnt <= 3'd0;
      else if (load_q != 4'd0)
        loaded_cnt <= loaded_cnt + 3'd1;
    end
  end

  assign MEM_RD            = fetch_active;
  assign MEM_ADDR          = fetch_addr;
  assign BUS128            = bus_q;
  assign SIG_LOAD          = load_q[WORD_SIG];
  assign FF_LOAD           = load_q[WORD_FF];
  assign TEMPLATE_LOAD     = load_q[WORD_TMPL];
  assign CYCLE_LOAD        = load_q[WORD_CYC];
  assign SIG_TRANSFER      = xfer;
  assign FF_TRANSFER       = xfer;
  assign TEMPLATE_TRANSFER = xfer;
  assign CYCLE_TRANSFER    = xfer;
  assign PERFORM_TEST      = perf_q;
  assign BUSY              = busy;
  assign DONE              = (state == ST_FINISH);
  assign ERR_CFG           = err_cfg_q;
  assign ERR_UNDERRUN      = err_und_q;

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- Upstream feeder for the DUT control wrapper. It fetches test vectors from the vector RAM and drives the shared 128-bit bus, one vector at a time.
- Each vector is four 128-bit words: signal, FF format, template and cycle. The block pulses the matching LOAD strobe as each word reaches the bus.
- When the test-cycle boundary arrives, it pulses all four TRANSFER strobes together. It also owns PERFORM_TEST and the run status.

Parameters:
- ADDR_W, 12, vector RAM word-address width.
- CNT_W, 10, vector-count width.
- MIN_LEN, 8, minimum legal CYCLE_LENGTH_1.

Ports:
- CLK  in  1  clock
- RST  in  1  reset (async, active-high)
- START  in  1  1-cycle pulse; begins a run (ignored unless BUSY=0)
- ABORT  in  1  stops the run at the next edge
- BASE_ADDR  in  ADDR_W  word address of vector 0, word 0
- NUM_VECTORS  in  CNT_W  number of vectors in the run
- CYCLE_LENGTH_1  in  8  test-cycle length in clocks
- MEM_RD  out  1  read request
- MEM_ADDR  out  ADDR_W  read address
- MEM_GNT  in  1  request accepted this cycle
- MEM_DATA  in  128  valid exactly 1 cycle after an accepted request
- BUS128  out  128  word presented to the DUT wrapper
- SIG_LOAD, FF_LOAD, TEMPLATE_LOAD, CYCLE_LOAD  out  1 each  pre-buffer load strobes
- SIG_TRANSFER, FF_TRANSFER, TEMPLATE_TRANSFER, CYCLE_TRANSFER  out  1 each  transfer strobes, always identical
- PERFORM_TEST  out  1  a vector is live in the output buffers
- BUSY  out  1  run in progress
- DONE  out  1  1-cycle pulse at run end
- ERR_CFG  out  1  sticky; cleared by the next accepted START
- ERR_UNDERRUN  out  1  sticky; cleared by the next accepted START

Behaviour:
- Reset: all outputs 0 and the FSM enters IDLE. Any run in progress is dropped immediately.
- Clock and reset: one clock; reset is asynchronous and active-high. The ports are named CLK and RST.
- Vector layout: vector n, word k lives at address BASE_ADDR + 4n + k, with wrap-around modulo 2^ADDR_W.
  - k=0 signal → SIG_LOAD
  - k=1 FF → FF_LOAD
  - k=2 template → TEMPLATE_LOAD
  - k=3 cycle → CYCLE_LOAD
- Fetch pipeline:
  - MEM_RD is held with MEM_ADDR stable until MEM_GNT=1, then the address advances.
  - Data is registered: if a request is accepted at cycle t, BUS128 = MEM_DATA and the matching LOAD strobe are high at t+2 for exactly one cycle.
  - At most one LOAD strobe is high in any cycle. BUS128 holds its last value when no strobe is high.
- START handling: CYCLE_LENGTH_1, NUM_VECTORS and BASE_ADDR are sampled on START.
  - If CYCLE_LENGTH_1 < MIN_LEN: ERR_CFG=1 and DONE pulses the next cycle; no memory access or transfer occurs.
  - If NUM_VECTORS = 0: DONE pulses the next cycle and nothing else happens.
- FSM states: IDLE, PRIME, RUN, DRAIN, FINISH.
  - IDLE → PRIME on a valid START; BUSY=1 from the next cycle.
  - PRIME fetches vector 0. The cycle after its 4th LOAD, the TRANSFER strobes pulse, then the FSM enters RUN.
  - Entering RUN: the period counter = 0 and PERFORM_TEST = 1, both starting the cycle after the transfer.
  - In RUN, the counter runs 0..L-1 and wraps, where L is the sampled CYCLE_LENGTH_1. Fetching of vector n+1 starts at count 0.
  - Boundary is count = L-1. If all 4 loads of the next vector are complete, the TRANSFER strobes pulse in the boundary cycle. Every vector is therefore live for exactly L clocks.
  - Once the last vector has been transferred, no more fetches occur and the FSM enters DRAIN.
  - DRAIN: at the next boundary, PERFORM_TEST goes to 0 from the following cycle and the FSM enters FINISH.
  - FINISH: DONE=1 and BUSY=0 for one cycle, then IDLE.
- Underrun: if the next vector's loads are incomplete at a boundary:
  - no transfer occurs;
  - ERR_UNDERRUN=1 and PERFORM_TEST=0 from the next cycle;
  - FINISH follows, and data from outstanding reads is discarded (no LOAD strobes).
- ABORT: same as underrun, without setting the error flag. ABORT takes priority over a same-cycle boundary transfer. ABORT in IDLE is ignored.
- START while BUSY is ignored.
- Counter widths: the period counter is 8 bits; the vector counter is CNT_W bits and counts down to 0 without wrapping.

Decomposition:
- Package vec_seq_pkg holds:
  - the FSM state enum;
  - word-index constants (WORD_SIG=0, WORD_FF=1, WORD_TMPL=2, WORD_CYC=3);
  - the MIN_LEN default.
- Sub-module vector_period_ctr: the 8-bit wrap counter with clear and enable inputs and a boundary flag output.

Test Plan:
1. BASE_ADDR=0x010, NUM_VECTORS=2, L=10, MEM_GNT tied to 1 → loads at the expected t+2 cycles, BUS128 carrying words 0x010–0x017 in order. The first transfer comes 1 cycle after the 4th load; the second transfer is exactly 10 cycles later. PERFORM_TEST is high for 20 cycles, then DONE pulses once.
2. L=7 on START → ERR_CFG=1, DONE pulse, MEM_RD never asserted, no strobes.
3. L=8 with MEM_GNT low for 3 cycles during vector 1's fetch → boundary reached with loads incomplete. Result: ERR_UNDERRUN=1, no second transfer, PERFORM_TEST falls, DONE pulses.
4. ABORT asserted in the same cycle as a boundary → no TRANSFER strobes, ERR_UNDERRUN stays 0, DONE the next cycle.
5. NUM_VECTORS=0 → DONE after 1 cycle, no LOAD/TRANSFER; START issued while BUSY is ignored.
6. RST asserted mid-RUN, asynchronously → all outputs 0 before the next edge; a new START afterwards runs normally.
